// File: rtl/tick_prescaler.sv
// Two-stage tick prescaler: a programmable base divisor produces ms ticks, and an optional
// second stage (built only when TICK_PRESCALER_SEC_EN is defined) divides ms ticks into sec ticks.
module tick_prescaler #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 5000,
  parameter int SEC_DIV     = 1000,
  parameter int SEC_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             ms,
  output logic             sec
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pend_val;
  logic             pend_flag;
  logic [CNT_W-1:0] div_last;
  logic             wrap;

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  always_comb begin
    div_last = '0;
    if (div_reg != '0) div_last = div_reg - 1'b1;
    wrap = en && !clr && (cnt == div_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      div_reg   <= CNT_W'(DIV_DEFAULT);
      pend_val  <= '0;
      pend_flag <= 1'b0;
      ms        <= 1'b0;
      div_ack   <= 1'b0;
    end else begin
      ms      <= 1'b0;
      div_ack <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (wrap) begin
        cnt <= '0;
        ms  <= 1'b1;
        if (pend_flag) begin
          div_reg   <= pend_val;
          pend_flag <= 1'b0;
          div_ack   <= 1'b1;
        end
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
      // Placed last so a load on an application edge re-arms the flag for the next wrap.
      if (div_load) begin
        pend_val  <= div_val;
        pend_flag <= 1'b1;
      end
    end
  end

`ifdef TICK_PRESCALER_SEC_EN
  logic [SEC_W-1:0] scnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      sec  <= 1'b0;
    end else begin
      sec <= 1'b0;
      if (clr) begin
        scnt <= '0;
      end else if (wrap) begin
        if (scnt == SEC_W'(SEC_DIV - 1)) begin
          scnt <= '0;
          sec  <= 1'b1;
        end else begin
          scnt <= scnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_sec_cfg;
  assign unused_sec_cfg = (SEC_DIV + SEC_W) != 0;
  assign sec = 1'b0;
`endif

endmodule

// File: tb/tb_tick_prescaler.sv
// Randomized and directed bench for tick_prescaler against a period-counting reference model.
// The sec expectation follows TICK_PRESCALER_SEC_EN as defined for the build.
module tb_tick_prescaler;

  localparam int CNT_W   = 8;
  localparam int DIV_DEF = 12;
  localparam int SEC_DIV = 3;
  localparam int SEC_W   = 2;
`ifdef TICK_PRESCALER_SEC_EN
  localparam bit SEC_ON = 1'b1;
`else
  localparam bit SEC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             div_load = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_ack, ms, sec;

  tick_prescaler #(
    .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF), .SEC_DIV(SEC_DIV), .SEC_W(SEC_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .div_val(div_val),
    .div_load(div_load), .div_ack(div_ack), .ms(ms), .sec(sec)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed enabled cycles in the current period, divisor in force,
  // optional pending divisor, and ms ticks seen since the last clear/reset.
  int m_elapsed, m_div, m_pend, m_nms;
  bit m_have;
  bit e_ms, e_sec, e_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_div = DIV_DEF; m_pend = 0; m_have = 0; m_nms = 0;
    e_ms = 0; e_sec = 0; e_ack = 0;
  endtask

  task automatic model_edge();
    int eff;
    e_ms = 0; e_sec = 0; e_ack = 0;
    eff = (m_div < 1) ? 1 : m_div;
    if (clr) begin
      m_elapsed = 0;
      m_nms = 0;
    end else if (en) begin
      m_elapsed++;
      if (m_elapsed >= eff) begin
        m_elapsed = 0;
        e_ms = 1;
        m_nms++;
        if (SEC_ON && (m_nms % SEC_DIV == 0)) e_sec = 1;
        if (m_have) begin
          m_div = m_pend;
          m_have = 0;
          e_ack = 1;
        end
      end
    end
    if (div_load) begin
      m_pend = int'(div_val);
      m_have = 1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".ms"}, ms, e_ms);
    check({tag, ".sec"}, sec, e_sec);
    check({tag, ".ack"}, div_ack, e_ack);
  endtask

  task automatic run_until_ms(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!ms && n < budget);
  endtask

  int n;

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #8;
    check("rst.ms", ms, 0);
    check("rst.sec", sec, 0);
    check("rst.ack", div_ack, 0);
    @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;

    // Default period
    run_until_ms("def1", 100, n); check("def1.period", n, DIV_DEF);
    run_until_ms("def2", 100, n); check("def2.period", n, DIV_DEF);

    // Load mid-period: old period completes, then new divisor 5
    repeat (3) step("ld.pre");
    div_val = 8'd5; div_load = 1'b1;
    step("ld.cap");
    div_load = 1'b0;
    run_until_ms("ld.old", 100, n); check("ld.old_period", n, DIV_DEF - 4);
    check("ld.ack", div_ack, 1);
    run_until_ms("ld.new", 100, n); check("ld.new_period", n, 5);

    // Freeze with en low for 7 cycles at cnt=3
    repeat (3) step("frz.pre");
    en = 1'b0;
    repeat (7) step("frz.hold");
    en = 1'b1;
    run_until_ms("frz.post", 100, n); check("frz.remaining", n, 2);

    // Clear at cnt=4 together with a load of 9
    repeat (4) step("clr.pre");
    clr = 1'b1; div_load = 1'b1; div_val = 8'd9;
    step("clr.edge");
    clr = 1'b0; div_load = 1'b0;
    run_until_ms("clr.old", 100, n); check("clr.old_period", n, 5);
    check("clr.ack", div_ack, 1);
    run_until_ms("clr.new", 100, n); check("clr.new_period", n, 9);

    // Divisor 0 behaves as 1
    div_val = 8'd0; div_load = 1'b1;
    step("d0.cap");
    div_load = 1'b0;
    run_until_ms("d0.apply", 20, n); check("d0.ack", div_ack, 1);
    for (int i = 0; i < 4; i++) begin
      step("d0.run"); check("d0.ms_high", ms, 1);
    end

    // Divisor 1; the load coincides with a wrap so it applies one wrap later
    div_val = 8'd1; div_load = 1'b1;
    step("d1.cap");
    div_load = 1'b0;
    check("d1.no_early_ack", div_ack, 0);
    step("d1.apply"); check("d1.ack", div_ack, 1);
    for (int i = 0; i < 3; i++) begin
      step("d1.run"); check("d1.ms_high", ms, 1);
    end

    // Divisor 4, clear, then sec on every 3rd ms
    div_val = 8'd4; div_load = 1'b1;
    step("d4.cap");
    div_load = 1'b0;
    step("d4.apply");
    clr = 1'b1;
    step("d4.clr");
    clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      run_until_ms("sec", 20, n); check("sec.period", n, 4);
      check("sec.tick", sec, (SEC_ON && (k % 3 == 0)) ? 1 : 0);
    end

    // Async reset while ms high and a load is pending (captured on the wrap edge)
    repeat (3) step("ar.pre");
    div_val = 8'd7; div_load = 1'b1;
    step("ar.wrap");
    div_load = 1'b0;
    check("ar.ms_before", ms, 1);
    #2 rst = 1'b1;
    #1;
    check("ar.ms", ms, 0);
    check("ar.sec", sec, 0);
    check("ar.ack", div_ack, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_until_ms("ar.p1", 100, n); check("ar.p1_period", n, DIV_DEF);
    check("ar.no_ack", div_ack, 0);
    run_until_ms("ar.p2", 100, n); check("ar.p2_period", n, DIV_DEF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 59) == 0);
      div_load = ($urandom_range(0, 19) == 0);
      div_val  = CNT_W'($urandom_range(0, 15));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tick_prescaler.md
TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 Parameter CNT_W, default 16: width of the base counter, divisor and load bus.
REQ-002 Parameter DIV_DEFAULT, default 5000: base divisor in force after reset.
REQ-003 Parameter SEC_DIV, default 1000: number of ms ticks per sec tick.
REQ-004 Parameter SEC_W, default 10: width of the second-stage counter; shall satisfy 2^SEC_W >= SEC_DIV.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 en  in  1  count enable; low pauses both stages.
REQ-008 clr  in  1  synchronous clear of both counters.
REQ-009 div_val  in  CNT_W  new base divisor.
REQ-010 div_load  in  1  request to capture div_val.
REQ-011 div_ack  out  1  one-cycle pulse when a pending divisor takes effect.
REQ-012 ms  out  1  registered one-cycle tick, once every div_reg enabled cycles.
REQ-013 sec  out  1  registered one-cycle tick, once every SEC_DIV ms ticks.

Function
REQ-014 Base counter cnt (CNT_W bits) shall increment on each edge with en=1 and clr=0.
- When cnt == div_reg-1, cnt shall wrap to 0 and ms shall be 1 in the following cycle.
- Otherwise ms shall be 0.
REQ-015 With en held high, ms period shall be exactly div_reg cycles; the first ms shall go high after the DIV_DEFAULT-th edge following reset release.
REQ-016 Effective divisor shall be max(div_reg,1).
- A divisor of 0 shall behave as 1.
- A divisor of 1 shall hold ms high on every enabled cycle.
REQ-017 div_load=1 shall capture div_val into a pending register and set a pending flag.
- A later div_load before application shall overwrite the pending value.
REQ-018 A pending divisor shall be applied only on a base-counter wrap edge: div_reg <= pending, flag cleared, div_ack=1 for the next cycle.
- The current period always completes with the old divisor.
REQ-019 div_load coinciding with a wrap edge shall be captured as pending and applied at the next wrap, not the current one.
REQ-020 en=0 shall freeze cnt and the second-stage counter; ms, sec and div_ack shall be 0 while frozen.
REQ-021 clr=1 shall set cnt and the second-stage counter to 0 and force ms, sec and div_ack to 0.
- clr has priority over en and over wrap/application.
- div_reg and the pending register/flag shall be unchanged; a div_load in the same cycle shall still be captured.
REQ-022 Second stage counter scnt (SEC_W bits) shall advance on each base wrap edge.
- When scnt == SEC_DIV-1 at a wrap edge, scnt shall wrap to 0 and sec shall be 1 in the same cycle as that ms.

Reset
REQ-023 rst=1 shall asynchronously force the following values, independent of clk: cnt=0, scnt=0, div_reg=DIV_DEFAULT, pending=0, flag=0, ms=0, sec=0, div_ack=0.
REQ-024 Reset asserted mid-period shall discard the partial count and any pending divisor.
- Counting restarts from 0 on the first edge after release.

Configuration
REQ-025 Macro TICK_PRESCALER_SEC_EN defined: second stage is built per REQ-022.
- Macro undefined: no scnt register, sec tied to constant 0, SEC_DIV and SEC_W unused.
- All other behaviour is identical in both builds.

Verification
REQ-026 DIV_DEFAULT=5000, en=1 after reset -> ms high at cycles 5000, 10000, 15000, each pulse exactly 1 cycle wide.
REQ-027 div_val=10, div_load pulsed at cycle 100 -> first ms at 5000 (old divisor), div_ack at 5000, next ms at 5010, 5020.
REQ-028 en low for 7 cycles starting at cnt=3 -> cnt holds at 3 and ms stays 0; the next ms is delayed by exactly 7 cycles.
REQ-029 clr at cnt=4 together with div_load(20) while divisor=10 -> cnt=0; ms 10 cycles later with div_ack; following ms 20 cycles later.
REQ-030 TICK_PRESCALER_SEC_EN on, divisor=4, SEC_DIV=3 -> sec coincides with every 3rd ms (cycles 12, 24); macro off -> sec constantly 0.
REQ-031 rst asserted between edges at cnt=2 with a pending load -> all outputs drop to 0 immediately; after release, ms period equals DIV_DEFAULT and no div_ack occurs.
